// File: rtl/y86_alu_pkg.sv
// Shared Y86 ALU definitions: word width, serial-subtractor state encoding and
// the condition-code flag bundle used by the ALU condition-code register.
package y86_alu_pkg;

    localparam int unsigned WORD_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sub_state_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through a single full-subtractor cell, producing
// the difference, unsigned borrow and ZF/SF/OF behind a start/done handshake.
module serial_subtractor
    import y86_alu_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             of_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bw_q, bw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    cc_t              cc_q, cc_d;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] res_shift;
    logic             accept;

    full_subtractor u_cell (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (bw_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    // New result bit enters at the MSB so the word is aligned after WIDTH shifts.
    assign res_shift = {cell_d, res_q[WIDTH-1:1]};
    // Start is honoured in IDLE and in DONE (back-to-back), never during RUN.
    assign accept    = start_i && (state_q != StRun);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        bw_d     = bw_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cc_d     = cc_q;

        unique case (state_q)
            StIdle: ;
            StRun: begin
                res_d  = res_shift;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                bw_d   = cell_bout;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d  = StDone;
                    cnt_d    = '0;
                    diff_d   = res_shift;
                    borrow_d = cell_bout;
                    cc_d.zf  = (res_shift == '0);
                    cc_d.sf  = cell_d;
                    cc_d.of  = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d = StRun;
            cnt_d   = '0;
            bw_d    = 1'b0;
            a_sh_d  = a_i;
            b_sh_d  = b_i;
            a_msb_d = a_i[WIDTH-1];
            b_msb_d = b_i[WIDTH-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            bw_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            bw_q     <= bw_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cc_q     <= cc_d;
        end
    end

    assign busy_o   = (state_q == StRun);
    assign done_o   = (state_q == StDone);
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign zf_o     = cc_q.zf;
    assign sf_o     = cc_q.sf;
    assign of_o     = cc_q.of;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: 64-bit directed vectors plus an
// exhaustive 2-bit instance; monitors pop expectations on every done pulse.
module tb_serial_subtractor;

    typedef struct {
        logic [63:0] diff;
        logic        borrow;
        logic        zf;
        logic        sf;
        logic        of;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    logic        start64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        busy64, done64, borrow64, zf64, sf64, of64;
    logic [63:0] diff64;

    logic        start2 = 1'b0;
    logic [1:0]  a2 = '0, b2 = '0;
    logic        busy2, done2, borrow2, zf2, sf2, of2;
    logic [1:0]  diff2;

    exp_t        q64[$];
    exp_t        q2[$];
    exp_t        e64, e2;
    int unsigned brun64 = 0, brun2 = 0;

    serial_subtractor #(.WIDTH(64)) u_dut64 (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start64),
        .a_i      (a64),
        .b_i      (b64),
        .busy_o   (busy64),
        .done_o   (done64),
        .diff_o   (diff64),
        .borrow_o (borrow64),
        .zf_o     (zf64),
        .sf_o     (sf64),
        .of_o     (of64)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start2),
        .a_i      (a2),
        .b_i      (b2),
        .busy_o   (busy2),
        .done_o   (done2),
        .diff_o   (diff2),
        .borrow_o (borrow2),
        .zf_o     (zf2),
        .sf_o     (sf2),
        .of_o     (of2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic exp_t model2(input logic [1:0] a, input logic [1:0] b);
        exp_t        e;
        logic [1:0]  d;
        d        = a - b;
        e.diff   = {62'd0, d};
        e.borrow = (a < b);
        e.zf     = (d == 2'd0);
        e.sf     = d[1];
        e.of     = (a[1] != b[1]) && (d[1] != a[1]);
        e.acc    = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done64) begin
            if (q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w64_unexpected_done actual=%h required=no_done", diff64);
            end else begin
                e64 = q64.pop_front();
                chk("w64_diff", diff64, e64.diff);
                chk("w64_borrow", {63'd0, borrow64}, {63'd0, e64.borrow});
                chk("w64_zf", {63'd0, zf64}, {63'd0, e64.zf});
                chk("w64_sf", {63'd0, sf64}, {63'd0, e64.sf});
                chk("w64_of", {63'd0, of64}, {63'd0, e64.of});
                chk("w64_latency", 64'(edge_cnt), 64'(e64.acc + 64));
                chk("w64_busy_cycles", 64'(brun64), 64'd64);
            end
        end
        if (!busy64) brun64 = 0;
        else         brun64++;
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w2_unexpected_done actual=%h required=no_done", diff2);
            end else begin
                e2 = q2.pop_front();
                chk("w2_diff", {62'd0, diff2}, e2.diff);
                chk("w2_borrow", {63'd0, borrow2}, {63'd0, e2.borrow});
                chk("w2_zf", {63'd0, zf2}, {63'd0, e2.zf});
                chk("w2_sf", {63'd0, sf2}, {63'd0, e2.sf});
                chk("w2_of", {63'd0, of2}, {63'd0, e2.of});
                chk("w2_latency", 64'(edge_cnt), 64'(e2.acc + 2));
                chk("w2_busy_cycles", 64'(brun2), 64'd2);
            end
        end
        if (!busy2) brun2 = 0;
        else        brun2++;
    end

    task automatic push64(input logic [63:0] d, input logic bo, input logic z,
                          input logic s, input logic o);
        exp_t e;
        e.diff = d; e.borrow = bo; e.zf = z; e.sf = s; e.of = o;
        e.acc  = edge_cnt;
        q64.push_back(e);
    endtask

    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] d,
                        input logic bo, input logic z, input logic s, input logic o);
        @(negedge clk);
        a64 = a; b64 = b; start64 = 1'b1;
        @(posedge clk); #1;
        push64(d, bo, z, s, o);
        start64 = 1'b0;
    endtask

    task automatic drain64(input int lim);
        int n = 0;
        while (q64.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (q64.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL w64_timeout actual=%0d_pending required=0", q64.size());
            q64.delete();
        end
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy64}, 64'd0);
        chk({tag, "_done"}, {63'd0, done64}, 64'd0);
        chk({tag, "_diff"}, diff64, 64'd0);
        chk({tag, "_borrow"}, {63'd0, borrow64}, 64'd0);
        chk({tag, "_zf"}, {63'd0, zf64}, 64'd0);
        chk({tag, "_sf"}, {63'd0, sf64}, 64'd0);
        chk({tag, "_of"}, {63'd0, of64}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_outputs_zero("por");
        chk("por_w2_busy", {63'd0, busy2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        op64(64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        drain64(200);
        op64(64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
        drain64(200);
        op64(64'h1234, 64'h1234, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain64(200);
        op64(64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        drain64(200);

        // A start pulse mid-RUN must be dropped, not queued.
        op64(64'h10, 64'h1, 64'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        a64 = 64'd7; b64 = 64'd9; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        drain64(200);
        repeat (80) @(negedge clk);

        // Abort mid-RUN: outputs clear, the aborted op never reports done.
        op64(64'h100, 64'h1, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        q64.delete();
        reset_outputs_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        op64(64'h55, 64'h22, 64'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        drain64(200);

        // Back-to-back with start held high; operands change before each accept.
        @(negedge clk);
        a64 = 64'd100; b64 = 64'd1; start64 = 1'b1;
        @(posedge clk); #1;
        push64(64'h63, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (64) @(posedge clk);
        #1;
        a64 = 64'd1; b64 = 64'd100;
        @(posedge clk); #1;
        push64(64'hFFFF_FFFF_FFFF_FF9D, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (64) @(posedge clk);
        #1;
        a64 = 64'hDEAD_BEEF; b64 = 64'hBEEF;
        @(posedge clk); #1;
        push64(64'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        start64 = 1'b0;
        drain64(300);
        repeat (70) @(negedge clk);

        // Exhaustive 2-bit instance.
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            @(negedge clk);
            a2 = 2'(i >> 2); b2 = 2'(i & 3); start2 = 1'b1;
            @(posedge clk); #1;
            e     = model2(a2, b2);
            e.acc = edge_cnt;
            q2.push_back(e);
            start2 = 1'b0;
            repeat (4) @(negedge clk);
        end
        if (q2.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL w2_timeout actual=%0d_pending required=0", q2.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
